r0_uart_monitor: RTL



---
 rtl/r0_uart_monitor.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/r0_uart_monitor.sv
`default_nettype none
// ============================================================================
// Module   : r0_uart_monitor
// Purpose  : Sends every new CPU r0 value over UART 8N1 as 8 hex chars + CR LF.
// Revision : 1.0  initial release
// ============================================================================
module r0_uart_monitor #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] r0,
    output logic        tx,
    output logic        busy,
    output logic [7:0]  overrun_cnt
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [3:0]        CR_BYTE   = 4'd8;
    localparam logic [3:0]        LF_BYTE   = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [3:0]        byte_q, byte_d;
    logic [31:0]       r0_q;
    logic [31:0]       frame_val_q, frame_val_d;
    logic [31:0]       pend_val_q, pend_val_d;
    logic              pend_q, pend_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic [7:0]        ovr_q, ovr_d;

    logic              chg;
    logic              baud_end;
    logic              absorb;
    logic [2:0]        bit_nx;
    logic [4:0]        nib_sh;
    logic [3:0]        nib;
    logic [7:0]        cur_byte;

    assign chg      = (r0 != r0_q);
    assign baud_end = (baud_q == BAUD_LAST);
    assign bit_nx   = bit_q + 3'd1;

    // Character currently on the wire: hex digit of frame_val, then CR, LF.
    always_comb begin
        nib_sh = 5'd28 - {byte_q[2:0], 2'b00};
        nib    = 4'(frame_val_q >> nib_sh);
        if (byte_q == CR_BYTE) begin
            cur_byte = 8'h0D;
        end else if (byte_q == LF_BYTE) begin
            cur_byte = 8'h0A;
        end else if (nib < 4'd10) begin
            cur_byte = {4'h3, nib};
        end else begin
            cur_byte = 8'h37 + {4'h0, nib};
        end
    end

    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        frame_val_d = frame_val_q;
        pend_d      = pend_q;
        pend_val_d  = pend_val_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        ovr_d       = ovr_q;
        absorb      = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + BAUD_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (chg) begin
                    state_d     = S_START;
                    frame_val_d = r0;
                    byte_d      = '0;
                    bit_d       = '0;
                    baud_d      = '0;
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                    absorb      = 1'b1;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = cur_byte[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nx;
                        tx_d  = cur_byte[bit_nx];
                    end
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    state_d = S_START;
                    tx_d    = 1'b0;
                    bit_d   = '0;
                    if (byte_q != LF_BYTE) begin
                        byte_d = byte_q + 4'd1;
                    end else begin
                        // Frame end: live change beats the buffered value.
                        byte_d = '0;
                        if (chg) begin
                            frame_val_d = r0;
                            pend_d      = 1'b0;
                            absorb      = 1'b1;
                        end else if (pend_q) begin
                            frame_val_d = pend_val_q;
                            pend_d      = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (chg && !absorb) begin
            pend_d     = 1'b1;
            pend_val_d = r0;
        end
        // A change while a value is still buffered always discards one value.
        if (chg && pend_q && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            r0_q        <= '0;
            frame_val_q <= '0;
            pend_val_q  <= '0;
            pend_q      <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            ovr_q       <= '0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            r0_q        <= r0;
            frame_val_q <= frame_val_d;
            pend_val_q  <= pend_val_d;
            pend_q      <= pend_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
        end
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign overrun_cnt = ovr_q;

endmodule
`default_nettype wire
